// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM encoding,
// default geometry and the instruction driven when no fetch data is valid.
package icache_pkg;

   localparam int          LINES_DEF = 16;
   localparam int          WPL_DEF   = 4;
   localparam int          WB        = $clog2(WPL_DEF);
   localparam int          IB        = $clog2(LINES_DEF);
   localparam int          TAG_W     = 32 - IB - WB - 2;
   localparam logic [31:0] NOP_INST  = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REFILL   = 2'd1,
      WAIT_LOW = 2'd2,
      RESP     = 2'd3
   } state_t;

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the cache: one full-line write port and one
// combinational read port that returns hit and the selected word.
module icache_line_array #(
   parameter int LINES          = 16,
   parameter int WORDS_PER_LINE = 4,
   parameter int TAG_BITS       = 24
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [$clog2(LINES)-1:0]          rd_idx,
   input  logic [TAG_BITS-1:0]               rd_tag,
   input  logic [$clog2(WORDS_PER_LINE)-1:0] rd_wsel,
   output logic                              rd_hit,
   output logic [31:0]                       rd_word,
   input  logic                              wr_en,
   input  logic [$clog2(LINES)-1:0]          wr_idx,
   input  logic [TAG_BITS-1:0]               wr_tag,
   input  logic [32*WORDS_PER_LINE-1:0]      wr_line
);

   logic [LINES-1:0]            valid;
   logic [TAG_BITS-1:0]         tags [LINES];
   logic [32*WORDS_PER_LINE-1:0] data [LINES];

   assign rd_hit  = valid[rd_idx] && (tags[rd_idx] == rd_tag);
   assign rd_word = data[rd_idx][32*rd_wsel +: 32];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= '0;
      end else if (wr_en) begin
         valid[wr_idx] <= 1'b1;
      end
   end

   // NOTE: tag and data arrays carry no reset; a line is only ever read
   // through its valid bit, so clearing valid alone is sufficient.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tags[wr_idx] <= wr_tag;
         data[wr_idx] <= wr_line;
      end
   end

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache between IF and the instruction ROM:
// same-cycle hits in IDLE, full-line refill over a req/ready level handshake.
module icache_dm
   import icache_pkg::*;
#(
   parameter int          LINES          = LINES_DEF,
   parameter int          WORDS_PER_LINE = WPL_DEF,
   parameter logic [31:0] RESET_INST     = NOP_INST
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          if_req_Icache_i,
   input  logic [31:0]                   if_addr_i,
   input  logic                          fc_jump_flag_Icache_i,
   input  logic                          fc_bk_Icache_i,
   output logic                          Icache_hit_o,
   output logic                          Icache_ready_o,
   output logic [31:0]                   Icache_inst_o,
   output logic                          rom_req_o,
   output logic [31:0]                   rom_addr_o,
   input  logic                          rom_ready_i,
   input  logic [32*WORDS_PER_LINE-1:0]  rom_data_i
);

   localparam int          WORD_BITS  = $clog2(WORDS_PER_LINE);
   localparam int          INDEX_BITS = $clog2(LINES);
   localparam int          TAG_BITS   = 32 - INDEX_BITS - WORD_BITS - 2;
   localparam logic [31:0] OFF_MASK   = (32'd1 << (2 + WORD_BITS)) - 32'd1;

   state_t                 state;
   logic                   rdy_q;
   logic                   pending;
   logic [WORD_BITS-1:0]   word_sel;
   logic [31:0]            resp_word;
   logic                   arr_hit;
   logic [31:0]            arr_word;
   logic                   hit;
   logic                   rom_edge;
   logic                   unused_ok;

   assign unused_ok = ^if_addr_i[1:0];

   icache_line_array #(
      .LINES          (LINES),
      .WORDS_PER_LINE (WORDS_PER_LINE),
      .TAG_BITS       (TAG_BITS)
   ) u_array (
      .clk     (clk),
      .rst_n   (rst_n),
      .rd_idx  (if_addr_i[2+WORD_BITS +: INDEX_BITS]),
      .rd_tag  (if_addr_i[31 -: TAG_BITS]),
      .rd_wsel (if_addr_i[2 +: WORD_BITS]),
      .rd_hit  (arr_hit),
      .rd_word (arr_word),
      .wr_en   (state == REFILL && rom_edge),
      .wr_idx  (rom_addr_o[2+WORD_BITS +: INDEX_BITS]),
      .wr_tag  (rom_addr_o[31 -: TAG_BITS]),
      .wr_line (rom_data_i)
   );

   assign rom_edge       = rom_ready_i && !rdy_q;
   assign hit            = (state == IDLE) && if_req_Icache_i && arr_hit && !fc_bk_Icache_i;
   assign Icache_hit_o   = hit;
   assign Icache_ready_o = hit || (state == RESP && !fc_jump_flag_Icache_i);
   assign Icache_inst_o  = hit ? arr_word :
                           (state == RESP && !fc_jump_flag_Icache_i) ? resp_word : RESET_INST;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         rdy_q      <= 1'b0;
         pending    <= 1'b0;
         word_sel   <= '0;
         resp_word  <= RESET_INST;
         rom_req_o  <= 1'b0;
         rom_addr_o <= '0;
      end else begin
         rdy_q <= rom_ready_i;
         case (state)
            IDLE: begin
               if (if_req_Icache_i && !fc_bk_Icache_i && !arr_hit) begin
                  rom_addr_o <= if_addr_i & ~OFF_MASK;
                  word_sel   <= if_addr_i[2 +: WORD_BITS];
                  pending    <= 1'b1;
                  rom_req_o  <= 1'b1;
                  state      <= REFILL;
               end
            end
            REFILL: begin
               if (fc_jump_flag_Icache_i) pending <= 1'b0;
               if (rom_edge) begin
                  rom_req_o <= 1'b0;
                  resp_word <= rom_data_i[32*word_sel +: 32];
                  // A discarded fetch still has ready high here, so it must drain via WAIT_LOW.
                  state     <= (pending && !fc_jump_flag_Icache_i) ? RESP : WAIT_LOW;
               end
            end
            WAIT_LOW: begin
               if (!rom_ready_i) state <= IDLE;
            end
            RESP: begin
               if (fc_jump_flag_Icache_i) begin
                  pending <= 1'b0;
                  state   <= IDLE;
               end else if (!fc_bk_Icache_i) begin
                  pending <= 1'b0;
                  state   <= rom_ready_i ? WAIT_LOW : IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
